// File: rtl/ast_arb_pkg.sv
// Shared types and helpers for the packet-level round-robin stream arbiter.
package ast_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Index width that stays legal (>= 1 bit) for any input count.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ast_arb_rr_picker.sv
// Combinational round-robin picker: first set request strictly after 'last',
// wrapping around, via a double-width rotate followed by a priority encode.
module ast_arb_rr_picker
  import ast_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_i,
  output logic [LW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [LW-1:0]  w_off;
  logic [LW:0]    w_sum;

  always_comb begin
    w_dbl = {req_i, req_i} >> ({1'b0, last_i} + (LW+1)'(1));
    w_rot = w_dbl[N-1:0];
    w_off = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (w_rot[i]) w_off = LW'(i);
    end
    // Undo the rotation: offset is relative to last+1, modulo N.
    w_sum = {1'b0, last_i} + {1'b0, w_off} + (LW+1)'(1);
    if (w_sum >= (LW+1)'(N)) w_sum = w_sum - (LW+1)'(N);
  end

  assign gnt_idx_o = w_sum[LW-1:0];
  assign gnt_vld_o = |req_i;

endmodule

// File: rtl/ast_arb.sv
// Packet-level round-robin Avalon-ST mux: grants one input for a whole
// sop..eop packet and tags each output beat with the source index.
module ast_arb
  import ast_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int CHANNEL_WIDTH = 8,
  parameter int RX_DIR        = 4
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic [RX_DIR-1:0]        arb_mask_i,
  input  logic [DATA_WIDTH-1:0]    ast_data_i [RX_DIR],
  input  logic [RX_DIR-1:0]        ast_startofpacket_i,
  input  logic [RX_DIR-1:0]        ast_endofpacket_i,
  input  logic [EMPTY_WIDTH-1:0]   ast_empty_i [RX_DIR],
  input  logic [RX_DIR-1:0]        ast_valid_i,
  output logic [RX_DIR-1:0]        ast_ready_o,
  output logic [DATA_WIDTH-1:0]    ast_data_o,
  output logic                     ast_startofpacket_o,
  output logic                     ast_endofpacket_o,
  output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
  output logic                     ast_valid_o,
  input  logic                     ast_ready_i,
  output arb_state_t               dbg_state_o
);

  localparam int LW = idx_w(RX_DIR);

  // Handshake: a beat moves on a clock edge where valid and ready are both 1;
  // ready never depends on the same-port valid, and held beats stay stable.

  arb_state_t              r_state, w_state_nxt;
  logic [LW-1:0]           r_grant, r_rr_last, w_pick;
  logic                    w_pick_vld, w_out_en, w_accept, w_acc_eop;
  logic [RX_DIR-1:0]       w_req, w_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_sop, r_eop, r_valid;
  logic [EMPTY_WIDTH-1:0]  r_empty;
  logic [CHANNEL_WIDTH-1:0] r_chan;

  assign w_req    = ast_valid_i & ast_startofpacket_i & arb_mask_i;
  assign w_out_en = ~r_valid | ast_ready_i;

  ast_arb_rr_picker #(.N(RX_DIR), .LW(LW)) u_picker (
    .req_i     (w_req),
    .last_i    (r_rr_last),
    .gnt_idx_o (w_pick),
    .gnt_vld_o (w_pick_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_acc_eop   = 1'b0;
    case (r_state)
      ARB_IDLE: if (w_pick_vld) w_state_nxt = ARB_BUSY;
      ARB_BUSY: begin
        w_ready[r_grant] = w_out_en;
        w_accept         = ast_valid_i[r_grant] & w_out_en;
        w_acc_eop        = w_accept & ast_endofpacket_i[r_grant];
        if (w_acc_eop) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state   <= ARB_IDLE;
      r_grant   <= '0;
      r_rr_last <= LW'(RX_DIR-1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_IDLE && w_pick_vld) r_grant <= w_pick;
      if (w_acc_eop) r_rr_last <= r_grant;
    end
  end

  // Output register freezes entirely while a beat is held against backpressure.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_empty <= '0;
      r_chan  <= '0;
    end else if (w_out_en) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_data  <= ast_data_i[r_grant];
        r_sop   <= ast_startofpacket_i[r_grant];
        r_eop   <= ast_endofpacket_i[r_grant];
        r_empty <= ast_empty_i[r_grant];
        r_chan  <= CHANNEL_WIDTH'(r_grant);
      end
    end
  end

  assign ast_ready_o         = w_ready;
  assign ast_valid_o         = r_valid;
  assign ast_data_o          = r_data;
  assign ast_startofpacket_o = r_sop;
  assign ast_endofpacket_o   = r_eop;
  assign ast_empty_o         = r_empty;
  assign ast_channel_o       = r_chan;
  assign dbg_state_o         = r_state;

endmodule

// File: tb/tb_ast_arb.sv
// Self-checking bench for ast_arb: per-source packet queues, per-channel
// expected queues, round-robin order model and hold-stability monitor.
`timescale 1ns/1ps
module tb_ast_arb;
  import ast_arb_pkg::*;

  localparam int DW = 64;
  localparam int EW = 3;
  localparam int CW = 8;
  localparam int N  = 4;
  localparam int BW = DW + EW + 2;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  mask;
  logic [DW-1:0] d_i [N];
  logic [EW-1:0] emp_i [N];
  logic [N-1:0]  sop_i, eop_i, vld_i, rdy_o;
  logic [DW-1:0] d_o;
  logic          sop_o, eop_o, vld_o, rdy_i;
  logic [EW-1:0] emp_o;
  logic [CW-1:0] ch_o;
  arb_state_t    dbg;

  ast_arb #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW), .RX_DIR(N)) dut (
    .clk_i               (clk),
    .arst_n_i            (arst_n),
    .arb_mask_i          (mask),
    .ast_data_i          (d_i),
    .ast_startofpacket_i (sop_i),
    .ast_endofpacket_i   (eop_i),
    .ast_empty_i         (emp_i),
    .ast_valid_i         (vld_i),
    .ast_ready_o         (rdy_o),
    .ast_data_o          (d_o),
    .ast_startofpacket_o (sop_o),
    .ast_endofpacket_o   (eop_o),
    .ast_empty_o         (emp_o),
    .ast_channel_o       (ch_o),
    .ast_valid_o         (vld_o),
    .ast_ready_i         (rdy_i),
    .dbg_state_o         (dbg)
  );

  // ---------------- model state / scoreboard ----------------
  logic [BW-1:0] src_q [N][$];
  logic [BW-1:0] exp_q [N][$];
  int            sop_ch_q[$];
  int            n_vec, n_err, cyc, vld_pct, rdy_pct, first_out_cyc, cur_ch, gap;
  logic [N-1:0]  ok_rdy;
  bit            chk_gap, in_pkt, hold_pend, seen_eop;
  logic [CW+BW-1:0] hold_val;
  logic [BW-1:0] last_got;

  function automatic int rr_next(input int prev, input logic [N-1:0] m);
    for (int o = 1; o <= N; o++) if (m[(prev + o) % N]) return (prev + o) % N;
    return -1;
  endfunction

  function automatic bit drained(input logic [N-1:0] wm);
    for (int k = 0; k < N; k++) if (wm[k] && exp_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic add_pkt(input int k, input int len);
    logic [BW-1:0] b;
    logic [EW-1:0] e;
    for (int i = 0; i < len; i++) begin
      e = (i == len-1) ? EW'($urandom_range(7)) : '0;
      b = {(i == 0), (i == len-1), e, $urandom, $urandom};
      src_q[k].push_back(b);
      exp_q[k].push_back(b);
    end
  endtask

  task automatic drive();
    logic [BW-1:0] b;
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0 && int'($urandom_range(99)) < vld_pct) begin
        b        = src_q[k][0];
        vld_i[k] = 1'b1;
        sop_i[k] = b[BW-1];
        eop_i[k] = b[BW-2];
        emp_i[k] = b[DW+EW-1:DW];
        d_i[k]   = b[DW-1:0];
      end else begin
        vld_i[k] = 1'b0;
        sop_i[k] = 1'b0;
        eop_i[k] = 1'b0;
        emp_i[k] = '0;
        d_i[k]   = {$urandom, $urandom};
      end
    end
    rdy_i = (int'($urandom_range(99)) < rdy_pct);
  endtask

  task automatic flush();
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    sop_ch_q.delete();
    in_pkt = 0; hold_pend = 0; seen_eop = 0; gap = 0; first_out_cyc = -1;
  endtask

  // One clock: monitor at negedge, then input handshakes retire at posedge.
  task automatic tick();
    logic [N-1:0]  acc;
    logic [BW-1:0] got, exp;
    int ch;
    @(negedge clk);
    cyc++;
    n_vec++;
    if ($countones(rdy_o) > 1 || (rdy_o & ~ok_rdy) != '0) begin
      n_err++;
      $display("FAIL ready_o: got %b, required one-hot0 within %b", rdy_o, ok_rdy);
    end
    if (hold_pend) begin
      n_vec++;
      if (!vld_o || {ch_o, sop_o, eop_o, emp_o, d_o} !== hold_val) begin
        n_err++;
        $display("FAIL hold_stable: got v=%0b %h, required v=1 %h", vld_o,
                 {ch_o, sop_o, eop_o, emp_o, d_o}, hold_val);
      end
    end
    hold_pend = vld_o && !rdy_i;
    hold_val  = {ch_o, sop_o, eop_o, emp_o, d_o};
    if (vld_o && first_out_cyc < 0) first_out_cyc = cyc;
    if (vld_o && rdy_i) begin
      got = {sop_o, eop_o, emp_o, d_o};
      ch  = int'(ch_o);
      last_got = got;
      n_vec++;
      if (ch >= N || exp_q[ch].size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: ch=%0d beat=%h, required no beat", ch, got);
      end else begin
        exp = exp_q[ch].pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL beat_ch%0d: got %h, required %h", ch, got, exp);
        end
      end
      n_vec++;
      if (sop_o ? in_pkt : (!in_pkt || ch != cur_ch)) begin
        n_err++;
        $display("FAIL interleave: ch=%0d sop=%0b, required open_pkt=%0b on ch %0d", ch, sop_o, in_pkt, cur_ch);
      end
      if (sop_o) begin
        sop_ch_q.push_back(ch);
        if (chk_gap && seen_eop) begin
          n_vec++;
          if (gap != 1) begin
            n_err++;
            $display("FAIL bubble: got %0d idle cycles, required 1", gap);
          end
        end
      end
      if (eop_o) begin seen_eop = 1; gap = 0; end
      in_pkt = !eop_o;
      cur_ch = ch;
    end
    if (!vld_o) gap++;
    acc = vld_i & rdy_o;
    @(posedge clk);
    for (int k = 0; k < N; k++) if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    #1;
    drive();
  endtask

  task automatic run_drain(input logic [N-1:0] wm, input int budget);
    int t = 0;
    while (!drained(wm) && t < budget) begin tick(); t++; end
    n_vec++;
    if (!drained(wm)) begin
      n_err++;
      $display("FAIL drain_timeout: outputs still owed after %0d cycles, required 0", budget);
    end
    repeat (3) tick();
  endtask

  task automatic apply_reset();
    arst_n = 1'b0;
    flush();
    mask = '1; ok_rdy = '1; vld_pct = 100; rdy_pct = 100; chk_gap = 0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic check_zero_outputs(input string tag);
    n_vec++;
    if (vld_o !== 1'b0 || sop_o !== 1'b0 || eop_o !== 1'b0) begin
      n_err++; $display("FAIL %s_ctl: got v/s/e=%b%b%b, required 000", tag, vld_o, sop_o, eop_o);
    end
    n_vec++;
    if (d_o !== '0 || emp_o !== '0 || ch_o !== '0) begin
      n_err++; $display("FAIL %s_data: got d=%h e=%0d ch=%0d, required 0", tag, d_o, emp_o, ch_o);
    end
    n_vec++;
    if (rdy_o !== '0) begin n_err++; $display("FAIL %s_ready: got %b, required 0000", tag, rdy_o); end
    n_vec++;
    if (dbg !== ARB_IDLE) begin n_err++; $display("FAIL %s_state: got %0d, required IDLE", tag, dbg); end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #12;
    check_zero_outputs("reset");
  endtask

  task automatic test_single_beat();
    logic [BW-1:0] b;
    int c0;
    apply_reset();
    b = {1'b1, 1'b1, 3'd3, 64'h0000_0000_0000_00A5};
    src_q[2].push_back(b);
    exp_q[2].push_back(b);
    c0 = cyc;
    drive();
    run_drain(4'b0100, 50);
    n_vec++;
    if (first_out_cyc != c0 + 3) begin
      n_err++; $display("FAIL single_latency: got %0d, required %0d", first_out_cyc - c0, 3);
    end
    n_vec++;
    if (sop_ch_q.size() != 1 || sop_ch_q[0] != 2 || last_got !== b) begin
      n_err++; $display("FAIL single_beat: got %0d pkts beat %h, required 1 pkt ch2 %h", sop_ch_q.size(), last_got, b);
    end
  endtask

  task automatic test_all_requesting();
    int prev = N - 1, e;
    apply_reset();
    chk_gap = 1;
    for (int p = 0; p < 2; p++) for (int k = 0; k < N; k++) add_pkt(k, 3);
    drive();
    run_drain('1, 500);
    n_vec++;
    if (sop_ch_q.size() != 2*N) begin
      n_err++; $display("FAIL rr_count: got %0d, required %0d", sop_ch_q.size(), 2*N);
    end
    for (int i = 0; i < sop_ch_q.size(); i++) begin
      e = rr_next(prev, '1);
      n_vec++;
      if (sop_ch_q[i] != e) begin
        n_err++; $display("FAIL rr_order[%0d]: got ch %0d, required %0d", i, sop_ch_q[i], e);
      end
      prev = e;
    end
  endtask

  task automatic test_random_backpressure();
    apply_reset();
    vld_pct = 70;
    rdy_pct = 50;
    for (int p = 0; p < 4; p++) begin
      add_pkt(1, $urandom_range(1, 64));
      add_pkt(3, $urandom_range(1, 64));
    end
    drive();
    run_drain('1, 20000);
  endtask

  task automatic test_mask();
    int prev = N - 1, e, n0, n2;
    apply_reset();
    mask = 4'b1010;
    ok_rdy = 4'b1010;
    for (int p = 0; p < 3; p++) for (int k = 0; k < N; k++) add_pkt(k, $urandom_range(2, 4));
    n0 = src_q[0].size();
    n2 = src_q[2].size();
    drive();
    run_drain(4'b1010, 2000);
    n_vec++;
    if (sop_ch_q.size() != 6) begin
      n_err++; $display("FAIL mask_count: got %0d, required 6", sop_ch_q.size());
    end
    for (int i = 0; i < sop_ch_q.size(); i++) begin
      e = rr_next(prev, 4'b1010);
      n_vec++;
      if (sop_ch_q[i] != e) begin
        n_err++; $display("FAIL mask_order[%0d]: got ch %0d, required %0d", i, sop_ch_q[i], e);
      end
      prev = e;
    end
    n_vec++;
    if (src_q[0].size() != n0 || src_q[2].size() != n2) begin
      n_err++; $display("FAIL mask_blocked: got %0d/%0d beats left, required %0d/%0d", src_q[0].size(), src_q[2].size(), n0, n2);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    add_pkt(1, 20);
    drive();
    repeat (6) tick();
    #2;
    arst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    flush();
    drive();
    @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk);
    #1;
    add_pkt(3, 2);
    add_pkt(0, 2);
    drive();
    run_drain('1, 200);
    n_vec++;
    if (sop_ch_q.size() != 2 || sop_ch_q[0] != 0) begin
      n_err++; $display("FAIL post_reset_first: got %0d pkts first ch %0d, required 2 pkts first ch 0",
                        sop_ch_q.size(), (sop_ch_q.size() > 0) ? sop_ch_q[0] : -1);
    end
  endtask

  task automatic test_fairness();
    int n0, cnt0 = 0;
    bit found = 0;
    apply_reset();
    for (int p = 0; p < 6; p++) add_pkt(0, 4);
    drive();
    repeat (7) tick();
    n0 = sop_ch_q.size();
    add_pkt(3, 3);
    drive();
    run_drain('1, 1000);
    for (int i = n0; i < sop_ch_q.size(); i++) begin
      if (sop_ch_q[i] == 3) begin found = 1; break; end
      cnt0++;
    end
    n_vec++;
    if (!found || cnt0 > 1) begin
      n_err++; $display("FAIL fairness: got found=%0b after %0d ch0 pkts, required found=1 after <=1", found, cnt0);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    mask = '1; ok_rdy = '1; vld_pct = 100; rdy_pct = 100; chk_gap = 0;
    flush();
    drive();
    test_reset();
    test_single_beat();
    test_all_requesting();
    test_random_backpressure();
    test_mask();
    test_reset_mid_packet();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
